mem_arbiter: RTL

//   Arbitrates the two datapath memory ports onto the single physical memory port:

---
 rtl/mem_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Purpose : Round-robin arbiter placing the instruction-fetch port (0, read
//           only) and the load/store port (1, read/write) onto one physical
//           memory port. Completions are routed back to the granted port only.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // Port 0: instruction fetch
    input  logic              mem_read_0,
    input  logic [ADDR_W-1:0] mem_address_0,
    output logic              mem_resp_0,
    output logic [DATA_W-1:0] mem_rdata_0,
    // Port 1: load/store
    input  logic              mem_read_1,
    input  logic              mem_write_1,
    input  logic [ADDR_W-1:0] mem_address_1,
    input  logic [DATA_W-1:0] mem_wdata_1,
    input  logic [1:0]        mem_byte_enable,
    output logic              mem_resp_1,
    output logic [DATA_W-1:0] mem_rdata_1,
    // Physical memory port
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [DATA_W-1:0] pmem_wdata,
    output logic [1:0]        pmem_byte_enable,
    input  logic              pmem_resp,
    input  logic [DATA_W-1:0] pmem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GNT0 = 2'd1,
        S_GNT1 = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   last_gnt_q, last_gnt_d;   // port granted most recently

    logic   w_req0;
    logic   w_req1;

    assign w_req0 = mem_read_0;
    assign w_req1 = mem_read_1 | mem_write_1;

    // State and round-robin pointer; last_gnt resets to 1 so port 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // Next-state: grant from IDLE, hold until pmem_resp, then one DONE bubble
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_req0 && (!w_req1 || last_gnt_q)) begin
                    state_d    = S_GNT0;
                    last_gnt_d = 1'b0;
                end else if (w_req1) begin
                    state_d    = S_GNT1;
                    last_gnt_d = 1'b1;
                end
            end
            S_GNT0:  if (pmem_resp) state_d = S_DONE;
            S_GNT1:  if (pmem_resp) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output mux: pmem follows the granted port; responses only to that port.
    // Gating with rst_n keeps every output at zero while reset is held.
    always_comb begin
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        pmem_address     = '0;
        pmem_wdata       = '0;
        pmem_byte_enable = 2'b00;
        mem_resp_0       = 1'b0;
        mem_rdata_0      = '0;
        mem_resp_1       = 1'b0;
        mem_rdata_1      = '0;
        if (rst_n) begin
            case (state_q)
                S_GNT0: begin
                    pmem_read        = mem_read_0;
                    pmem_address     = mem_address_0;
                    pmem_byte_enable = 2'b11;
                    mem_resp_0       = pmem_resp;
                    mem_rdata_0      = pmem_resp ? pmem_rdata : '0;
                end
                S_GNT1: begin
                    // Read+write together is illegal; the write wins
                    pmem_read        = mem_read_1 & ~mem_write_1;
                    pmem_write       = mem_write_1;
                    pmem_address     = mem_address_1;
                    pmem_wdata       = mem_wdata_1;
                    pmem_byte_enable = mem_byte_enable;
                    mem_resp_1       = pmem_resp;
                    mem_rdata_1      = pmem_resp ? pmem_rdata : '0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
